// File: rtl/cmp_rs_pkg.sv
// Shared types for the integer compare reservation station.
package cmp_rs_pkg;

    localparam int unsigned RS_ID_WIDTH = 5;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned CRF_WIDTH   = 3;

    typedef struct packed {
        logic cmp_signed;
        logic cmp_l;
    } cmp_decode_t;

    typedef struct packed {
        logic                   busy;
        logic [DATA_WIDTH-1:0]  op1;
        logic                   op1_valid;
        logic [RS_ID_WIDTH-1:0] op1_tag;
        logic [DATA_WIDTH-1:0]  op2;
        logic                   op2_valid;
        logic [RS_ID_WIDTH-1:0] op2_tag;
        logic                   so;
        logic                   so_valid;
        logic [RS_ID_WIDTH-1:0] so_tag;
        logic [CRF_WIDTH-1:0]   crf;
        cmp_decode_t            control;
    } cmp_rs_entry_t;

    // True when a broadcast supplies a still-missing operand.
    function automatic logic tag_hit(input logic                   bus_valid,
                                     input logic [RS_ID_WIDTH-1:0] bus_id,
                                     input logic [RS_ID_WIDTH-1:0] tag,
                                     input logic                   valid);
        return bus_valid && !valid && (tag == bus_id);
    endfunction

endpackage

// File: rtl/cmp_rs_select.sv
// Lowest-index priority encoder: one-hot grant plus binary index.
module cmp_rs_select #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/cmp_rs.sv
// Compare-unit reservation station: operand wakeup from GPR/XER broadcasts
// and in-order-by-index issue of ready entries.
module cmp_rs
    import cmp_rs_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RS_ID_BASE = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   disp_valid,
    output logic                   disp_ready,
    output logic [RS_ID_WIDTH-1:0] disp_rs_id,
    input  logic [DATA_WIDTH-1:0]  disp_op1,
    input  logic [DATA_WIDTH-1:0]  disp_op2,
    input  logic                   disp_op1_valid,
    input  logic                   disp_op2_valid,
    input  logic [RS_ID_WIDTH-1:0] disp_op1_tag,
    input  logic [RS_ID_WIDTH-1:0] disp_op2_tag,
    input  logic                   disp_so,
    input  logic                   disp_so_valid,
    input  logic [RS_ID_WIDTH-1:0] disp_so_tag,
    input  logic [CRF_WIDTH-1:0]   disp_crf,
    input  cmp_decode_t            disp_control,
    input  logic                   gpr_bus_valid,
    input  logic [RS_ID_WIDTH-1:0] gpr_bus_rs_id,
    input  logic [DATA_WIDTH-1:0]  gpr_bus_data,
    input  logic                   xer_bus_valid,
    input  logic [RS_ID_WIDTH-1:0] xer_bus_rs_id,
    input  logic                   xer_bus_so,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id,
    output logic [CRF_WIDTH-1:0]   issue_crf,
    output logic [DATA_WIDTH-1:0]  issue_op1,
    output logic [DATA_WIDTH-1:0]  issue_op2,
    output logic                   issue_so,
    output cmp_decode_t            issue_control
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    cmp_rs_entry_t ent     [DEPTH];
    cmp_rs_entry_t ent_nxt [DEPTH];
    cmp_rs_entry_t disp_entry;

    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] rdy_vec;
    logic [DEPTH-1:0] free_grant;
    logic [DEPTH-1:0] rdy_grant;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             free_any;
    logic             rdy_any;
    logic             disp_fire;
    logic             issue_fire;

    // Free/ready vectors come from registered state only.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            free_vec[i] = !ent[i].busy;
            rdy_vec[i]  = ent[i].busy && ent[i].op1_valid && ent[i].op2_valid && ent[i].so_valid;
        end
    end

    cmp_rs_select #(.N(DEPTH), .IDX_W(IDX_W)) u_free_sel (
        .req   (free_vec),
        .grant (free_grant),
        .idx   (free_idx),
        .any   (free_any)
    );

    cmp_rs_select #(.N(DEPTH), .IDX_W(IDX_W)) u_rdy_sel (
        .req   (rdy_vec),
        .grant (rdy_grant),
        .idx   (sel_idx),
        .any   (rdy_any)
    );

    assign disp_ready    = rst_n && free_any;
    assign disp_rs_id    = RS_ID_WIDTH'(RS_ID_BASE) + RS_ID_WIDTH'(free_idx);
    assign disp_fire     = disp_valid && disp_ready;

    assign issue_valid   = rdy_any;
    assign issue_fire    = issue_valid && issue_ready;
    assign issue_rs_id   = RS_ID_WIDTH'(RS_ID_BASE) + RS_ID_WIDTH'(sel_idx);
    assign issue_crf     = ent[sel_idx].crf;
    assign issue_op1     = ent[sel_idx].op1;
    assign issue_op2     = ent[sel_idx].op2;
    assign issue_so      = ent[sel_idx].so;
    assign issue_control = ent[sel_idx].control;

    // New entry image, with same-cycle broadcast bypass for missing operands.
    always_comb begin
        disp_entry           = '0;
        disp_entry.busy      = 1'b1;
        disp_entry.op1       = disp_op1;
        disp_entry.op1_valid = disp_op1_valid;
        disp_entry.op1_tag   = disp_op1_tag;
        disp_entry.op2       = disp_op2;
        disp_entry.op2_valid = disp_op2_valid;
        disp_entry.op2_tag   = disp_op2_tag;
        disp_entry.so        = disp_so;
        disp_entry.so_valid  = disp_so_valid;
        disp_entry.so_tag    = disp_so_tag;
        disp_entry.crf       = disp_crf;
        disp_entry.control   = disp_control;
        if (tag_hit(gpr_bus_valid, gpr_bus_rs_id, disp_op1_tag, disp_op1_valid)) begin
            disp_entry.op1       = gpr_bus_data;
            disp_entry.op1_valid = 1'b1;
        end
        if (tag_hit(gpr_bus_valid, gpr_bus_rs_id, disp_op2_tag, disp_op2_valid)) begin
            disp_entry.op2       = gpr_bus_data;
            disp_entry.op2_valid = 1'b1;
        end
        if (tag_hit(xer_bus_valid, xer_bus_rs_id, disp_so_tag, disp_so_valid)) begin
            disp_entry.so       = xer_bus_so;
            disp_entry.so_valid = 1'b1;
        end
    end

    // Per-entry update: capture, issue release, allocation, then flush wins.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            ent_nxt[i] = ent[i];
            if (ent[i].busy) begin
                if (tag_hit(gpr_bus_valid, gpr_bus_rs_id, ent[i].op1_tag, ent[i].op1_valid)) begin
                    ent_nxt[i].op1       = gpr_bus_data;
                    ent_nxt[i].op1_valid = 1'b1;
                end
                if (tag_hit(gpr_bus_valid, gpr_bus_rs_id, ent[i].op2_tag, ent[i].op2_valid)) begin
                    ent_nxt[i].op2       = gpr_bus_data;
                    ent_nxt[i].op2_valid = 1'b1;
                end
                if (tag_hit(xer_bus_valid, xer_bus_rs_id, ent[i].so_tag, ent[i].so_valid)) begin
                    ent_nxt[i].so       = xer_bus_so;
                    ent_nxt[i].so_valid = 1'b1;
                end
            end
            if (issue_fire && rdy_grant[i]) begin
                ent_nxt[i].busy = 1'b0;
            end
            if (disp_fire && free_grant[i]) begin
                ent_nxt[i] = disp_entry;
            end
            if (flush) begin
                ent_nxt[i].busy = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent[i] <= ent_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_cmp_rs.sv
// Directed self-checking bench for the compare reservation station.
module tb_cmp_rs;
    import cmp_rs_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic                   flush;
    logic                   disp_valid;
    logic                   disp_ready;
    logic [RS_ID_WIDTH-1:0] disp_rs_id;
    logic [DATA_WIDTH-1:0]  disp_op1;
    logic [DATA_WIDTH-1:0]  disp_op2;
    logic                   disp_op1_valid;
    logic                   disp_op2_valid;
    logic [RS_ID_WIDTH-1:0] disp_op1_tag;
    logic [RS_ID_WIDTH-1:0] disp_op2_tag;
    logic                   disp_so;
    logic                   disp_so_valid;
    logic [RS_ID_WIDTH-1:0] disp_so_tag;
    logic [CRF_WIDTH-1:0]   disp_crf;
    cmp_decode_t            disp_control;
    logic                   gpr_bus_valid;
    logic [RS_ID_WIDTH-1:0] gpr_bus_rs_id;
    logic [DATA_WIDTH-1:0]  gpr_bus_data;
    logic                   xer_bus_valid;
    logic [RS_ID_WIDTH-1:0] xer_bus_rs_id;
    logic                   xer_bus_so;
    logic                   issue_valid;
    logic                   issue_ready;
    logic [RS_ID_WIDTH-1:0] issue_rs_id;
    logic [CRF_WIDTH-1:0]   issue_crf;
    logic [DATA_WIDTH-1:0]  issue_op1;
    logic [DATA_WIDTH-1:0]  issue_op2;
    logic                   issue_so;
    cmp_decode_t            issue_control;

    int checks = 0;
    int errors = 0;

    cmp_rs #(.DEPTH(4), .RS_ID_BASE(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_rs_id     (disp_rs_id),
        .disp_op1       (disp_op1),
        .disp_op2       (disp_op2),
        .disp_op1_valid (disp_op1_valid),
        .disp_op2_valid (disp_op2_valid),
        .disp_op1_tag   (disp_op1_tag),
        .disp_op2_tag   (disp_op2_tag),
        .disp_so        (disp_so),
        .disp_so_valid  (disp_so_valid),
        .disp_so_tag    (disp_so_tag),
        .disp_crf       (disp_crf),
        .disp_control   (disp_control),
        .gpr_bus_valid  (gpr_bus_valid),
        .gpr_bus_rs_id  (gpr_bus_rs_id),
        .gpr_bus_data   (gpr_bus_data),
        .xer_bus_valid  (xer_bus_valid),
        .xer_bus_rs_id  (xer_bus_rs_id),
        .xer_bus_so     (xer_bus_so),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_rs_id    (issue_rs_id),
        .issue_crf      (issue_crf),
        .issue_op1      (issue_op1),
        .issue_op2      (issue_op2),
        .issue_so       (issue_so),
        .issue_control  (issue_control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush          = 1'b0;
        disp_valid     = 1'b0;
        disp_op1       = '0;
        disp_op2       = '0;
        disp_op1_valid = 1'b1;
        disp_op2_valid = 1'b1;
        disp_op1_tag   = '0;
        disp_op2_tag   = '0;
        disp_so        = 1'b0;
        disp_so_valid  = 1'b1;
        disp_so_tag    = '0;
        disp_crf       = '0;
        disp_control   = '0;
        gpr_bus_valid  = 1'b0;
        gpr_bus_rs_id  = '0;
        gpr_bus_data   = '0;
        xer_bus_valid  = 1'b0;
        xer_bus_rs_id  = '0;
        xer_bus_so     = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        issue_ready = 1'b0;
        idle_inputs();

        // Reset state
        #2;
        chk("rst_disp_ready", 32'(disp_ready), 0);
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_disp_rs_id", 32'(disp_rs_id), 8);
        chk("rst_issue_op1", issue_op1, 0);
        #10 rst_n = 1'b1;
        tick();
        chk("post_rst_disp_ready", 32'(disp_ready), 1);

        // Fully-ready dispatch issues one cycle later
        issue_ready             = 1'b1;
        disp_valid              = 1'b1;
        disp_op1                = 32'd5;
        disp_op2                = 32'd7;
        disp_crf                = 3'd2;
        disp_control.cmp_signed = 1'b1;
        chk("t1_disp_rs_id", 32'(disp_rs_id), 8);
        tick();
        idle_inputs();
        chk("t1_issue_valid", 32'(issue_valid), 1);
        chk("t1_issue_rs_id", 32'(issue_rs_id), 8);
        chk("t1_issue_op1", issue_op1, 5);
        chk("t1_issue_op2", issue_op2, 7);
        chk("t1_issue_crf", 32'(issue_crf), 2);
        chk("t1_issue_signed", 32'(issue_control.cmp_signed), 1);
        chk("t1_busy_rs_id", 32'(disp_rs_id), 9);
        tick();
        chk("t1_freed_valid", 32'(issue_valid), 0);
        chk("t1_freed_rs_id", 32'(disp_rs_id), 8);

        // Waiting op2 woken by matching broadcast, non-matching ignored
        disp_valid     = 1'b1;
        disp_op1       = 32'd1;
        disp_op2_valid = 1'b0;
        disp_op2_tag   = 5'd3;
        tick();
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin
                gpr_bus_valid = 1'b1;
                gpr_bus_rs_id = 5'd4;
                gpr_bus_data  = 32'hDEAD_BEEF;
            end else begin
                gpr_bus_valid = 1'b0;
            end
            chk("t2_wait_valid", 32'(issue_valid), 0);
            tick();
        end
        chk("t2_wrong_tag_valid", 32'(issue_valid), 0);
        gpr_bus_valid = 1'b1;
        gpr_bus_rs_id = 5'd3;
        gpr_bus_data  = 32'hFFFF_FFFF;
        chk("t2_capture_cycle_valid", 32'(issue_valid), 0);
        tick();
        idle_inputs();
        chk("t2_issue_valid", 32'(issue_valid), 1);
        chk("t2_issue_op2", issue_op2, 32'hFFFF_FFFF);
        chk("t2_issue_op1", issue_op1, 1);
        tick();
        chk("t2_drained", 32'(issue_valid), 0);

        // Dispatch-cycle bypass
        disp_valid     = 1'b1;
        disp_op1_valid = 1'b0;
        disp_op1_tag   = 5'd6;
        disp_op2       = 32'd2;
        gpr_bus_valid  = 1'b1;
        gpr_bus_rs_id  = 5'd6;
        gpr_bus_data   = 32'h10;
        tick();
        idle_inputs();
        chk("t3_issue_valid", 32'(issue_valid), 1);
        chk("t3_issue_op1", issue_op1, 32'h10);
        tick();

        // Fill to full, drop the extra dispatch, drain in index order
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_fill_ready", 32'(disp_ready), 1);
            chk("t4_fill_rs_id", 32'(disp_rs_id), 32'(8 + i));
            disp_valid = 1'b1;
            disp_op1   = 32'(100 + i);
            tick();
        end
        disp_op1 = 32'd999;
        chk("t4_full_ready", 32'(disp_ready), 0);
        tick();
        idle_inputs();
        issue_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain_valid", 32'(issue_valid), 1);
            chk("t4_drain_rs_id", 32'(issue_rs_id), 32'(8 + i));
            chk("t4_drain_op1", issue_op1, 32'(100 + i));
            tick();
            if (i == 0) chk("t4_ready_after_first", 32'(disp_ready), 1);
        end
        chk("t4_dropped_fifth", 32'(issue_valid), 0);

        // Flush overrides a same-cycle dispatch
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp_valid = 1'b1;
            disp_op1   = 32'(i);
            tick();
        end
        chk("t5_pre_flush_valid", 32'(issue_valid), 1);
        chk("t5_pre_flush_rs_id", 32'(disp_rs_id), 11);
        flush = 1'b1;
        tick();
        idle_inputs();
        chk("t5_flush_valid", 32'(issue_valid), 0);
        chk("t5_flush_rs_id", 32'(disp_rs_id), 8);
        chk("t5_flush_ready", 32'(disp_ready), 1);

        // Asynchronous reset mid-capture
        disp_valid = 1'b1;
        disp_op1   = 32'd42;
        tick();
        disp_op2_valid = 1'b0;
        disp_op2_tag   = 5'd5;
        tick();
        idle_inputs();
        chk("t6_pre_rst_valid", 32'(issue_valid), 1);
        gpr_bus_valid = 1'b1;
        gpr_bus_rs_id = 5'd5;
        gpr_bus_data  = 32'h55;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_issue_valid", 32'(issue_valid), 0);
        chk("t6_rst_disp_ready", 32'(disp_ready), 0);
        #4 rst_n = 1'b1;
        idle_inputs();
        tick();
        chk("t6_post_ready", 32'(disp_ready), 1);
        chk("t6_post_rs_id", 32'(disp_rs_id), 8);
        chk("t6_post_valid", 32'(issue_valid), 0);
        tick();
        chk("t6_still_empty", 32'(issue_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
